// File: rtl/tlb_dm.sv
// Direct-mapped, ASID-tagged TLB with a 1-cycle lookup, a single-entry fill port and full or per-ASID flush.
// Entry RAM has no reset; an invalidation sweep runs after rst and on every flush.
module tlb_dm #(
   parameter int unsigned TLB_DEPTH  = 10,
   parameter int unsigned PAGE_DEPTH = 12,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ASID_WIDTH = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               lk_valid,
   output logic                               lk_ready,
   input  logic [ADDR_WIDTH-1:0]              lk_vaddr,
   input  logic [ASID_WIDTH-1:0]              lk_asid,
   output logic                               rsp_valid,
   output logic                               rsp_hit,
   output logic [ADDR_WIDTH-1:0]              rsp_paddr,
   output logic [3:0]                         rsp_perm,
   input  logic                               fill_valid,
   input  logic [ADDR_WIDTH-PAGE_DEPTH-1:0]   fill_vpn,
   input  logic [ADDR_WIDTH-PAGE_DEPTH-1:0]   fill_ppn,
   input  logic [ASID_WIDTH-1:0]              fill_asid,
   input  logic                               fill_global,
   input  logic [3:0]                         fill_perm,
   input  logic                               flush_req,
   input  logic                               flush_by_asid,
   input  logic [ASID_WIDTH-1:0]              flush_asid,
   output logic                               busy
);

   localparam int unsigned VPN_W   = ADDR_WIDTH - PAGE_DEPTH;
   localparam int unsigned TAG_W   = VPN_W - TLB_DEPTH;
   localparam int unsigned ENTRIES = 1 << TLB_DEPTH;

   typedef struct packed {
      logic                  valid;
      logic                  is_global;
      logic [ASID_WIDTH-1:0] asid;
      logic [TAG_W-1:0]      tag;
      logic [VPN_W-1:0]      ppn;
      logic [3:0]            perm;
   } entry_t;

   typedef enum logic [1:0] {
      SWEEP_ALL,
      SWEEP_RD,
      SWEEP_WR,
      READY
   } state_t;

   state_t                 r_state;
   logic [TLB_DEPTH-1:0]   r_idx;
   logic [ASID_WIDTH-1:0]  r_flush_asid;

   entry_t                 r_mem [ENTRIES];
   entry_t                 r_rd;

   logic                   r_pend;
   logic [TAG_W-1:0]       r_lk_tag;
   logic [PAGE_DEPTH-1:0]  r_lk_off;
   logic [ASID_WIDTH-1:0]  r_lk_asid;
   logic                   r_hold_hit;
   logic [ADDR_WIDTH-1:0]  r_hold_paddr;
   logic [3:0]             r_hold_perm;

   logic                   w_ready;
   logic                   w_accept;
   logic                   w_last;
   logic [TLB_DEPTH-1:0]   w_rd_idx;
   logic                   w_we;
   logic [TLB_DEPTH-1:0]   w_wr_idx;
   entry_t                 w_wr_data;
   logic                   w_hit;
   logic [ADDR_WIDTH-1:0]  w_paddr;
   logic [3:0]             w_perm;

   assign w_ready  = (r_state == READY);
   assign w_accept = w_ready && !flush_req && lk_valid;
   assign w_last   = (r_idx == {TLB_DEPTH{1'b1}});
   assign busy     = !w_ready;
   assign lk_ready = w_ready && !flush_req;

   // Single read port: lookups own it in READY, the per-ASID sweep otherwise.
   assign w_rd_idx = w_ready ? lk_vaddr[PAGE_DEPTH +: TLB_DEPTH] : r_idx;

   always_comb begin
      w_we      = 1'b0;
      w_wr_idx  = r_idx;
      w_wr_data = '0;
      case (r_state)
         SWEEP_ALL: w_we = 1'b1;
         SWEEP_WR: begin
            if (r_rd.valid && !r_rd.is_global && (r_rd.asid == r_flush_asid)) begin
               w_we            = 1'b1;
               w_wr_data       = r_rd;
               w_wr_data.valid = 1'b0;
            end
         end
         READY: begin
            if (fill_valid) begin
               w_we                = 1'b1;
               w_wr_idx            = fill_vpn[TLB_DEPTH-1:0];
               w_wr_data.valid     = 1'b1;
               w_wr_data.is_global = fill_global;
               w_wr_data.asid      = fill_asid;
               w_wr_data.tag       = fill_vpn[VPN_W-1 -: TAG_W];
               w_wr_data.ppn       = fill_ppn;
               w_wr_data.perm      = fill_perm;
            end
         end
         default: w_we = 1'b0;
      endcase
      if (rst) w_we = 1'b0;
   end

   // Read-before-write RAM: a same-cycle fill is not visible to the lookup.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_wr_idx] <= w_wr_data;
      r_rd <= r_mem[w_rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SWEEP_ALL;
         r_idx   <= '0;
      end else begin
         case (r_state)
            SWEEP_ALL: begin
               r_idx <= r_idx + TLB_DEPTH'(1);
               if (w_last) r_state <= READY;
            end
            SWEEP_RD: r_state <= SWEEP_WR;
            SWEEP_WR: begin
               r_idx   <= r_idx + TLB_DEPTH'(1);
               r_state <= w_last ? READY : SWEEP_RD;
            end
            READY: begin
               if (flush_req) begin
                  r_idx        <= '0;
                  r_flush_asid <= flush_asid;
                  r_state      <= flush_by_asid ? SWEEP_RD : SWEEP_ALL;
               end
            end
            default: r_state <= SWEEP_ALL;
         endcase
      end
   end

   assign w_hit   = r_rd.valid && (r_rd.tag == r_lk_tag) &&
                    (r_rd.is_global || (r_rd.asid == r_lk_asid));
   assign w_paddr = w_hit ? {r_rd.ppn, r_lk_off} : '0;
   assign w_perm  = w_hit ? r_rd.perm : 4'h0;

   // Response fields follow the RAM output on the strobe cycle and are held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend       <= 1'b0;
         r_hold_hit   <= 1'b0;
         r_hold_paddr <= '0;
         r_hold_perm  <= 4'h0;
      end else begin
         r_pend <= w_accept;
         if (w_accept) begin
            r_lk_tag  <= lk_vaddr[ADDR_WIDTH-1 -: TAG_W];
            r_lk_off  <= lk_vaddr[PAGE_DEPTH-1:0];
            r_lk_asid <= lk_asid;
         end
         if (r_pend) begin
            r_hold_hit   <= w_hit;
            r_hold_paddr <= w_paddr;
            r_hold_perm  <= w_perm;
         end
      end
   end

   assign rsp_valid = r_pend;
   assign rsp_hit   = r_pend ? w_hit   : r_hold_hit;
   assign rsp_paddr = r_pend ? w_paddr : r_hold_paddr;
   assign rsp_perm  = r_pend ? w_perm  : r_hold_perm;

endmodule

// File: tb/tb_tlb_dm.sv
// Self-checking bench for tlb_dm: directed scenarios plus randomized traffic against a behavioural TLB model.
module tb_tlb_dm;

   localparam int NE = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        lk_valid;
   logic        lk_ready;
   logic [31:0] lk_vaddr;
   logic [7:0]  lk_asid;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [31:0] rsp_paddr;
   logic [3:0]  rsp_perm;
   logic        fill_valid;
   logic [19:0] fill_vpn;
   logic [19:0] fill_ppn;
   logic [7:0]  fill_asid;
   logic        fill_global;
   logic [3:0]  fill_perm;
   logic        flush_req;
   logic        flush_by_asid;
   logic [7:0]  flush_asid;
   logic        busy;

   always #5 clk = ~clk;

   tlb_dm dut (
      .clk(clk), .rst(rst),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_vaddr(lk_vaddr), .lk_asid(lk_asid),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_paddr(rsp_paddr), .rsp_perm(rsp_perm),
      .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .fill_asid(fill_asid),
      .fill_global(fill_global), .fill_perm(fill_perm),
      .flush_req(flush_req), .flush_by_asid(flush_by_asid), .flush_asid(flush_asid),
      .busy(busy)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one slot per index, tag = vpn / NE, plus a remaining-busy cycle count.
   bit          m_valid [NE];
   bit          m_glob  [NE];
   logic [7:0]  m_asid  [NE];
   int          m_tag   [NE];
   logic [19:0] m_ppn   [NE];
   logic [3:0]  m_perm  [NE];
   int          busy_left = 0;
   bit          e_valid   = 1'b0;
   bit          e_hit     = 1'b0;
   logic [31:0] e_paddr   = '0;
   logic [3:0]  e_perm    = '0;

   always @(posedge clk) begin
      int slot;
      int vpn;
      if (rst) begin
         for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
         busy_left = NE;
         e_valid = 1'b0; e_hit = 1'b0; e_paddr = '0; e_perm = '0;
      end else if (busy_left > 0) begin
         busy_left--;
         e_valid = 1'b0;
      end else begin
         e_valid = lk_valid && !flush_req;
         if (e_valid) begin
            vpn   = int'(lk_vaddr >> 12);
            slot  = vpn % NE;
            e_hit = m_valid[slot] && (m_tag[slot] == vpn / NE) &&
                    (m_glob[slot] || m_asid[slot] == lk_asid);
            e_paddr = e_hit ? {m_ppn[slot], lk_vaddr[11:0]} : 32'h0;
            e_perm  = e_hit ? m_perm[slot] : 4'h0;
         end
         if (fill_valid) begin
            slot = int'(fill_vpn) % NE;
            m_valid[slot] = 1'b1;
            m_glob[slot]  = fill_global;
            m_asid[slot]  = fill_asid;
            m_tag[slot]   = int'(fill_vpn) / NE;
            m_ppn[slot]   = fill_ppn;
            m_perm[slot]  = fill_perm;
         end
         if (flush_req) begin
            busy_left = flush_by_asid ? 2 * NE : NE;
            for (int i = 0; i < NE; i++)
               if (!flush_by_asid || (!m_glob[i] && m_asid[i] == flush_asid)) m_valid[i] = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("busy",      64'(busy),      64'(busy_left != 0));
         chk("lk_ready",  64'(lk_ready),  64'((busy_left == 0) && !flush_req));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
         chk("rsp_hit",   64'(rsp_hit),   64'(e_hit));
         chk("rsp_paddr", 64'(rsp_paddr), 64'(e_paddr));
         chk("rsp_perm",  64'(rsp_perm),  64'(e_perm));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 5000) begin
         n++;
         tick();
      end
   endtask

   task automatic do_fill(input logic [19:0] vpn, input logic [19:0] ppn, input logic [7:0] asid,
                          input logic glob, input logic [3:0] perm);
      fill_valid = 1'b1; fill_vpn = vpn; fill_ppn = ppn;
      fill_asid = asid; fill_global = glob; fill_perm = perm;
      tick();
      fill_valid = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] va, input logic [7:0] asid,
                         output logic h, output logic [31:0] pa, output logic [3:0] pm);
      lk_valid = 1'b1; lk_vaddr = va; lk_asid = asid;
      tick();
      lk_valid = 1'b0;
      h = rsp_hit; pa = rsp_paddr; pm = rsp_perm;
   endtask

   task automatic do_flush(input logic by_asid, input logic [7:0] asid, output int n);
      flush_req = 1'b1; flush_by_asid = by_asid; flush_asid = asid;
      tick();
      flush_req = 1'b0;
      count_busy(n);
   endtask

   initial begin
      logic        h;
      logic [31:0] pa;
      logic [3:0]  pm;
      int          n;
      int          cnt;

      rst = 1'b1; lk_valid = 1'b0; lk_vaddr = '0; lk_asid = '0;
      fill_valid = 1'b0; fill_vpn = '0; fill_ppn = '0; fill_asid = '0; fill_global = 1'b0; fill_perm = '0;
      flush_req = 1'b0; flush_by_asid = 1'b0; flush_asid = '0;
      tick(); tick();
      chk_en = 1'b1;
      chk("reset_busy",      64'(busy),      64'd1);
      chk("reset_lk_ready",  64'(lk_ready),  64'd0);
      chk("reset_rsp_paddr", 64'(rsp_paddr), 64'd0);

      rst = 1'b0;
      count_busy(n);
      chk("init_sweep_cycles", 64'(n), 64'd1024);
      chk("ready_after_sweep", 64'(lk_ready), 64'd1);
      lookup(32'hDEADB123, 8'd9, h, pa, pm);
      chk("empty_hit",   64'(h),  64'd0);
      chk("empty_paddr", 64'(pa), 64'd0);

      do_fill(20'h12345, 20'hABCDE, 8'd3, 1'b0, 4'hE);
      lookup(32'h12345678, 8'd3, h, pa, pm);
      chk("t2_hit",   64'(h),  64'd1);
      chk("t2_paddr", 64'(pa), 64'hABCDE678);
      chk("t2_perm",  64'(pm), 64'hE);
      lookup(32'h12345678, 8'd4, h, pa, pm);
      chk("t2_other_asid_hit", 64'(h), 64'd0);
      do_fill(20'h12345, 20'hABCDE, 8'd3, 1'b1, 4'hE);
      lookup(32'h12345678, 8'd4, h, pa, pm);
      chk("t2_global_hit",   64'(h),  64'd1);
      chk("t2_global_paddr", 64'(pa), 64'hABCDE678);

      do_fill(20'h00005, 20'h00001, 8'd0, 1'b0, 4'h8);
      do_fill(20'h00405, 20'h00002, 8'd0, 1'b0, 4'hC);
      lookup(32'h00005000, 8'd0, h, pa, pm);
      chk("t3_evicted_hit", 64'(h), 64'd0);
      lookup(32'h00405000, 8'd0, h, pa, pm);
      chk("t3_new_hit",   64'(h),  64'd1);
      chk("t3_new_paddr", 64'(pa), 64'h00002000);

      do_fill(20'h00010, 20'h00100, 8'd1, 1'b0, 4'hF);
      do_fill(20'h00011, 20'h00101, 8'd2, 1'b0, 4'hF);
      do_fill(20'h00012, 20'h00102, 8'd7, 1'b1, 4'hF);
      do_flush(1'b1, 8'd1, n);
      chk("t4_asid_flush_cycles", 64'(n), 64'd2048);
      lookup(32'h00010000, 8'd1, h, pa, pm);
      chk("t4_asid1_flushed", 64'(h), 64'd0);
      lookup(32'h00011000, 8'd2, h, pa, pm);
      chk("t4_asid2_kept", 64'(h), 64'd1);
      lookup(32'h00012000, 8'd5, h, pa, pm);
      chk("t4_global_kept",  64'(h),  64'd1);
      chk("t4_global_paddr", 64'(pa), 64'h00102000);
      do_flush(1'b0, 8'd0, n);
      chk("t4_full_flush_cycles", 64'(n), 64'd1024);
      lookup(32'h00011000, 8'd2, h, pa, pm);
      chk("t4_full_asid2", 64'(h), 64'd0);
      lookup(32'h00012000, 8'd5, h, pa, pm);
      chk("t4_full_global", 64'(h), 64'd0);

      // Same-cycle fill and lookup on index 7.
      fill_valid = 1'b1; fill_vpn = 20'h00007; fill_ppn = 20'h00777;
      fill_asid = 8'd0; fill_global = 1'b0; fill_perm = 4'hA;
      lk_valid = 1'b1; lk_vaddr = 32'h00007ABC; lk_asid = 8'd0;
      tick();
      fill_valid = 1'b0;
      chk("t5_same_cycle_hit", 64'(rsp_hit), 64'd0);
      tick();
      lk_valid = 1'b0;
      chk("t5_next_cycle_hit",   64'(rsp_hit),   64'd1);
      chk("t5_next_cycle_paddr", 64'(rsp_paddr), 64'h00777ABC);

      cnt = 0;
      lk_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         lk_vaddr = $urandom;
         lk_asid  = 8'($urandom_range(0, 3));
         tick();
         if (rsp_valid) cnt++;
      end
      lk_valid = 1'b0;
      tick();
      chk("t5_b2b_responses", 64'(cnt), 64'd100);

      // Reset in the middle of the initial sweep, with flush and fill attempts while busy.
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (300) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         flush_req = 1'b1; flush_by_asid = 1'b1; flush_asid = 8'd0;
         fill_valid = 1'b1; fill_vpn = 20'h00033; fill_ppn = 20'h00333; fill_asid = 8'd0; fill_global = 1'b1;
         tick();
      end
      flush_req = 1'b0; fill_valid = 1'b0;
      count_busy(n);
      chk("t6_restart_sweep_cycles", 64'(n + 10), 64'd1024);
      lookup(32'h00033000, 8'd0, h, pa, pm);
      chk("t6_fill_while_busy_dropped", 64'(h), 64'd0);

      // Randomized traffic over a small VPN space so indices collide and hits are frequent.
      for (int c = 0; c < 4000; c++) begin
         rst        = ($urandom_range(0, 2999) == 0);
         lk_valid   = ($urandom_range(0, 1) == 1);
         lk_vaddr   = {10'($urandom_range(0, 3)), 10'($urandom_range(0, 15)), 12'($urandom)};
         lk_asid    = 8'($urandom_range(0, 3));
         fill_valid = ($urandom_range(0, 3) == 0);
         fill_vpn   = {10'($urandom_range(0, 3)), 10'($urandom_range(0, 15))};
         fill_ppn   = 20'($urandom);
         fill_asid  = 8'($urandom_range(0, 3));
         fill_global = ($urandom_range(0, 3) == 0);
         fill_perm  = 4'($urandom);
         flush_req  = ($urandom_range(0, 599) == 0);
         flush_by_asid = ($urandom_range(0, 1) == 1);
         flush_asid = 8'($urandom_range(0, 3));
         tick();
      end
      rst = 1'b0; lk_valid = 1'b0; fill_valid = 1'b0; flush_req = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
